l1a_sequence_checker: RTL and testbench

Consumes L1A words read from ram_L1A and verifies that they form a contiguous, incrementing trigger-number sequence. Sits directly downstream of the L1A read-request stage: it takes that stage's rd_req/rd_addr pulses, realigns them to the RAM read latency, and compares each returned word against the expected next L1A. It produces per-word check pulses, error counters and a first-error snapshot for the LV2 status registers.

---
 rtl/l1a_chk_pkg.sv | 28 ++
 rtl/l1a_rd_align.sv | 48 ++++
 rtl/l1a_sequence_checker.sv | 162 ++++++++++++++++
 tb/tb_l1a_sequence_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1a_chk_pkg.sv
// ----------------------------------------------------------------------------
// l1a_chk_pkg : shared types, default widths and helpers for the L1A checker
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package l1a_chk_pkg;

  typedef enum logic [0:0] {
    SEED  = 1'b0,
    TRACK = 1'b1
  } chk_state_e;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  // Holds at the all-ones value of a 'width'-bit counter instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1a_rd_align.sv
// ----------------------------------------------------------------------------
// l1a_rd_align : RD_LAT-deep {valid, addr} delay line aligning reads to ram_q
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module l1a_rd_align #(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT-1:0]             valid_q, valid_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d[0] = in_valid & ~flush;
    addr_d[0]  = in_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush;
      addr_d[i]  = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/l1a_sequence_checker.sv
// ----------------------------------------------------------------------------
// l1a_sequence_checker : verifies ram_L1A words form an incrementing sequence
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module l1a_sequence_checker
  import l1a_chk_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              chk_valid,
  output logic              chk_ok,
  output logic              addr_skip,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  n_checked,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  logic              dv;
  logic [ADDR_W-1:0] daddr;

  chk_state_e        state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic              chk_valid_q, chk_valid_d;
  logic              chk_ok_q, chk_ok_d;
  logic              addr_skip_q, addr_skip_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  n_checked_q, n_checked_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
  logic [DATA_W-1:0] first_err_got_q, first_err_got_d;

  l1a_rd_align #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_align (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (clear),
    .in_valid  (rd_req),
    .in_addr   (rd_addr),
    .out_valid (dv),
    .out_addr  (daddr)
  );

  always_comb begin
    state_d          = state_q;
    expected_d       = expected_q;
    prev_addr_d      = prev_addr_q;
    chk_valid_d      = 1'b0;
    chk_ok_d         = 1'b0;
    addr_skip_d      = addr_skip_q;
    err_sticky_d     = err_sticky_q;
    n_checked_d      = n_checked_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    first_err_exp_d  = first_err_exp_q;
    first_err_got_d  = first_err_got_q;

    if (clear) begin
      state_d          = SEED;
      expected_d       = '0;
      prev_addr_d      = '0;
      addr_skip_d      = 1'b0;
      err_sticky_d     = 1'b0;
      n_checked_d      = '0;
      err_cnt_d        = '0;
      first_err_addr_d = '0;
      first_err_exp_d  = '0;
      first_err_got_d  = '0;
    end else if (dv) begin
      chk_valid_d = 1'b1;
      n_checked_d = CNT_W'(sat_inc(32'(n_checked_q), CNT_W));
      expected_d  = ram_q + DATA_ONE;
      prev_addr_d = daddr;
      state_d     = TRACK;
      case (state_q)
        SEED: chk_ok_d = 1'b1;
        TRACK: begin
          if (ram_q == expected_q) begin
            chk_ok_d = 1'b1;
          end else begin
            err_sticky_d = 1'b1;
            err_cnt_d    = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
            // err_sticky_q low means no mismatch since the last clear/reset
            if (!err_sticky_q) begin
              first_err_addr_d = daddr;
              first_err_exp_d  = expected_q;
              first_err_got_d  = ram_q;
            end
          end
          if (daddr != prev_addr_q + ADDR_ONE) begin
            addr_skip_d = 1'b1;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= SEED;
      expected_q       <= '0;
      prev_addr_q      <= '0;
      chk_valid_q      <= 1'b0;
      chk_ok_q         <= 1'b0;
      addr_skip_q      <= 1'b0;
      err_sticky_q     <= 1'b0;
      n_checked_q      <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      first_err_exp_q  <= '0;
      first_err_got_q  <= '0;
    end else begin
      state_q          <= state_d;
      expected_q       <= expected_d;
      prev_addr_q      <= prev_addr_d;
      chk_valid_q      <= chk_valid_d;
      chk_ok_q         <= chk_ok_d;
      addr_skip_q      <= addr_skip_d;
      err_sticky_q     <= err_sticky_d;
      n_checked_q      <= n_checked_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_exp_q  <= first_err_exp_d;
      first_err_got_q  <= first_err_got_d;
    end
  end

  assign chk_valid      = chk_valid_q;
  assign chk_ok         = chk_ok_q;
  assign addr_skip      = addr_skip_q;
  assign err_sticky     = err_sticky_q;
  assign n_checked      = n_checked_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_exp  = first_err_exp_q;
  assign first_err_got  = first_err_got_q;

endmodule

`default_nettype wire

// File: tb/tb_l1a_sequence_checker.sv
// ----------------------------------------------------------------------------
// tb_l1a_sequence_checker : table vectors, directed corners and random traffic
// Revision                : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_l1a_sequence_checker;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = 65535;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] ram_q = '0;
  logic              chk_valid, chk_ok, addr_skip, err_sticky;
  logic [CNT_W-1:0]  n_checked, err_cnt;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_exp, first_err_got;

  l1a_sequence_checker #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (RD_LAT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset_n (reset_n), .clear (clear), .rd_req (rd_req),
    .rd_addr (rd_addr), .ram_q (ram_q), .chk_valid (chk_valid), .chk_ok (chk_ok),
    .addr_skip (addr_skip), .err_sticky (err_sticky), .n_checked (n_checked),
    .err_cnt (err_cnt), .first_err_addr (first_err_addr),
    .first_err_exp (first_err_exp), .first_err_got (first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        ok;
    logic        skip;
    logic        err;
    logic [15:0] n;
    logic [15:0] e;
    logic [5:0]  fa;
    logic [31:0] fe;
    logic [31:0] fg;
  } obs_t;

  typedef struct {
    int          cyc;
    logic [5:0]  addr;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    logic        req;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        v;
    logic        ok;
    int          n;
    int          e;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b1;
  pend_t pq[$];
  logic [31:0] hist[8];

  // Reference model: the rules applied word by word in arrival order.
  bit          m_seeded;
  logic [31:0] m_exp;
  int          m_prev;
  bit          m_v, m_ok, m_skip, m_err;
  int          m_n, m_e;
  logic [5:0]  m_fa;
  logic [31:0] m_fe, m_fg;

  task automatic model_clear();
    m_seeded = 0; m_exp = 0; m_prev = 0; m_v = 0; m_ok = 0; m_skip = 0; m_err = 0;
    m_n = 0; m_e = 0; m_fa = 0; m_fe = 0; m_fg = 0;
  endtask

  task automatic model_word(input pend_t w);
    m_v = 1;
    if (m_n < CNT_MAX) m_n = m_n + 1;
    if (!m_seeded) begin
      m_ok = 1;
      m_seeded = 1;
    end else begin
      m_ok = (w.data == m_exp);
      if (!m_ok) begin
        if (!m_err) begin m_fa = w.addr; m_fe = m_exp; m_fg = w.data; end
        m_err = 1;
        if (m_e < CNT_MAX) m_e = m_e + 1;
      end
      if (int'(w.addr) != (m_prev + 1) % 64) m_skip = 1;
    end
    m_exp  = w.data + 32'd1;
    m_prev = int'(w.addr);
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.v = m_v; o.ok = m_ok; o.skip = m_skip; o.err = m_err;
    o.n = 16'(m_n); o.e = 16'(m_e); o.fa = m_fa; o.fe = m_fe; o.fg = m_fg;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.v = chk_valid; o.ok = chk_ok; o.skip = addr_skip; o.err = err_sticky;
    o.n = n_checked; o.e = err_cnt; o.fa = first_err_addr;
    o.fe = first_err_exp; o.fg = first_err_got;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t want);
    obs_t got;
    got = dut_obs();
    if (!want.v) begin got.ok = 1'b0; want.ok = 1'b0; end
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got v=%0b ok=%0b skip=%0b err=%0b n=%0d e=%0d fa=%0d fe=%h fg=%h ; want v=%0b ok=%0b skip=%0b err=%0b n=%0d e=%0d fa=%0d fe=%h fg=%h",
               name, cyc, got.v, got.ok, got.skip, got.err, got.n, got.e, got.fa, got.fe, got.fg,
               want.v, want.ok, want.skip, want.err, want.n, want.e, want.fa, want.fe, want.fg);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d (0x%h), want %0d (0x%h)", name, cyc, got, got, want, want);
    end
  endtask

  task automatic tick(input logic req, input logic [5:0] a, input logic [31:0] d, input logic clr);
    pend_t w;
    rd_req = req; rd_addr = a; clear = clr;
    ram_q = hist[(cyc - RD_LAT) & 7];
    hist[cyc & 7] = req ? d : $urandom;
    if (req && !clr) begin w.cyc = cyc; w.addr = a; w.data = d; pq.push_back(w); end
    @(posedge clk); #1;
    m_v = 0; m_ok = 0;
    if (clr) begin
      pq.delete();
      model_clear();
    end else if (pq.size() > 0 && pq[0].cyc == cyc - RD_LAT) begin
      w = pq.pop_front();
      model_word(w);
    end
    if (chk_en) check_obs("model", model_obs());
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0; rd_req = 1'b0; clear = 1'b0;
    #1;
    check_obs(name, '0);
    @(posedge clk); #1;
    cyc++;
    reset_n = 1'b1;
    pq.delete();
    model_clear();
  endtask

  initial begin
    vec_t tbl[7];
    int first_v, pulses;
    logic [5:0] la;
    logic [31:0] ld;

    tbl[0] = '{1'b1, 6'd0, 32'd10, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 6'd1, 32'd11, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{1'b1, 6'd2, 32'd13, 1'b1, 1'b1, 1, 0};
    tbl[3] = '{1'b1, 6'd3, 32'd14, 1'b1, 1'b1, 2, 0};
    tbl[4] = '{1'b0, 6'd0, 32'd0,  1'b1, 1'b0, 3, 1};
    tbl[5] = '{1'b0, 6'd0, 32'd0,  1'b1, 1'b1, 4, 1};
    tbl[6] = '{1'b0, 6'd0, 32'd0,  1'b0, 1'b0, 4, 1};

    for (int i = 0; i < 8; i++) hist[i] = '0;
    model_clear();
    do_reset("reset_state");
    idle(1);

    // 8 back-to-back reads, words 100..107
    first_v = -1; pulses = 0;
    for (int i = 0; i < 8 + RD_LAT + 1; i++) begin
      if (i < 8) tick(1'b1, 6'(i), 32'(100 + i), 1'b0);
      else       idle(1);
      if (chk_valid) begin
        pulses++;
        if (first_v < 0) first_v = i;
      end
    end
    check_val("first_latency", 32'(first_v), 32'(RD_LAT));
    check_val("burst_pulses", 32'(pulses), 32'd8);
    check_val("burst_n_checked", 32'(n_checked), 32'd8);
    check_val("burst_err_cnt", 32'(err_cnt), 32'd0);

    // Table: 10, 11, 13, 14 with one mismatch on the third word
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].req, tbl[i].addr, tbl[i].data, 1'b0);
      check_val($sformatf("tbl%0d_valid", i), 32'(chk_valid), 32'(tbl[i].v));
      if (tbl[i].v) check_val($sformatf("tbl%0d_ok", i), 32'(chk_ok), 32'(tbl[i].ok));
      check_val($sformatf("tbl%0d_n", i), 32'(n_checked), 32'(tbl[i].n));
      check_val($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].e));
    end
    check_val("snap_addr", 32'(first_err_addr), 32'd2);
    check_val("snap_exp", first_err_exp, 32'd12);
    check_val("snap_got", first_err_got, 32'd13);

    // Data wrap and legal address wrap
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    tick(1'b1, 6'd62, 32'hFFFF_FFFE, 1'b0);
    tick(1'b1, 6'd63, 32'hFFFF_FFFF, 1'b0);
    tick(1'b1, 6'd0,  32'h0000_0000, 1'b0);
    tick(1'b1, 6'd1,  32'h0000_0001, 1'b0);
    idle(RD_LAT + 1);
    check_val("wrap_err_cnt", 32'(err_cnt), 32'd0);
    check_val("wrap_addr_skip", 32'(addr_skip), 32'd0);

    // Address skip 5 -> 7 with correct data
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    tick(1'b1, 6'd5, 32'd500, 1'b0);
    tick(1'b1, 6'd7, 32'd501, 1'b0);
    idle(RD_LAT + 1);
    check_val("skip_addr_skip", 32'(addr_skip), 32'd1);
    check_val("skip_err_sticky", 32'(err_sticky), 32'd0);

    // clear coinciding with dv drops the word; next word seeds
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    tick(1'b1, 6'd9, 32'd900, 1'b0);
    for (int i = 1; i < RD_LAT; i++) idle(1);
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    check_val("clr_dv_valid", 32'(chk_valid), 32'd0);
    check_val("clr_dv_n", 32'(n_checked), 32'd0);
    tick(1'b1, 6'd20, 32'd7777, 1'b0);
    idle(RD_LAT);
    check_val("reseed_valid", 32'(chk_valid), 32'd1);
    check_val("reseed_ok", 32'(chk_ok), 32'd1);
    idle(1);

    // Randomized traffic with occasional gaps, skips, mismatches and clears
    la = 6'd0; ld = 32'd1000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        tick(1'b0, 6'd0, 32'd0, 1'b1);
      end else if ($urandom_range(0, 9) < 7) begin
        la = ($urandom_range(0, 9) == 0) ? 6'($urandom) : la + 6'd1;
        ld = ($urandom_range(0, 7) == 0) ? $urandom : ld + 32'd1;
        tick(1'b1, la, ld, 1'b0);
      end else begin
        idle(1);
      end
    end
    idle(RD_LAT + 1);

    // Reset pulsed mid-burst, then a fresh seed
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    tick(1'b1, 6'd0, 32'd1, 1'b0);
    tick(1'b1, 6'd1, 32'd9, 1'b0);
    tick(1'b1, 6'd2, 32'd3, 1'b0);
    tick(1'b1, 6'd3, 32'd4, 1'b0);
    do_reset("midburst_reset");
    idle(RD_LAT + 1);
    tick(1'b1, 6'd30, 32'd55, 1'b0);
    idle(RD_LAT + 1);

    // Saturation: 2^16+3 words that all miss expectation after the seed
    tick(1'b0, 6'd0, 32'd0, 1'b1);
    chk_en = 1'b0;
    for (int i = 0; i < 65536 + 3; i++) tick(1'b1, 6'(i), 32'd5, 1'b0);
    chk_en = 1'b1;
    idle(RD_LAT + 1);
    check_val("sat_n_checked", 32'(n_checked), 32'hFFFF);
    check_val("sat_err_cnt", 32'(err_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
